// File: rtl/bp_run_ctrl.sv
// Run controller for a branch-predictor core: resets the core, runs it until a
// halt instruction or a cycle limit, drains in-flight branches and exposes event counters.
module bp_run_ctrl #(
  parameter int unsigned CNT_WIDTH       = 32,
  parameter int unsigned CORE_RST_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter logic [31:0] HALT_INSN       = 32'h0000_0073,
  parameter int unsigned TIMEOUT         = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 br_instr_i,
  input  logic                 br_miss_i,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          t_instr_i,
  output logic                 core_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  input  logic                 rd_req_i,
  input  logic [1:0]           rd_addr_i,
  output logic                 rd_vld_o,
  output logic [CNT_WIDTH-1:0] rd_data_o
);

  localparam int unsigned PH_MAX = (CORE_RST_CYCLES > DRAIN_CYCLES) ? CORE_RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] RST_LAST   = PH_W'((CORE_RST_CYCLES > 0) ? CORE_RST_CYCLES - 1 : 0);
  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [63:0]     TIMEOUT_W  = 64'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PH_W-1:0]      ph_cnt;
  logic [CNT_WIDTH-1:0] cyc_cnt;
  logic [CNT_WIDTH-1:0] br_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;
  logic [31:0]          miss_pc;
  logic [CNT_WIDTH-1:0] cyc_inc;
  logic [CNT_WIDTH-1:0] rd_sel;
  logic                 launch;
  logic                 br_evt;
  logic                 miss_evt;
  logic                 halt;
  logic                 timeout_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign launch      = ((state == S_IDLE) || (state == S_DONE)) && start_i;
  assign br_evt      = ((state == S_RUN) || (state == S_DRAIN)) && br_instr_i;
  assign miss_evt    = br_evt && br_miss_i;
  assign halt        = (instr_i == HALT_INSN);
  assign cyc_inc     = sat_inc(cyc_cnt);
  // Compare on a 64-bit view so a TIMEOUT wider than the counter simply never fires
  assign timeout_hit = (64'(cyc_inc) >= TIMEOUT_W);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nxt = S_CORE_RST;
      S_CORE_RST:     if (ph_cnt == RST_LAST) state_nxt = S_RUN;
      S_RUN: begin
        if (halt)             state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_DRAIN:        if (ph_cnt == DRAIN_LAST) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // State register; status outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      core_rst_no <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        ph_cnt <= '0;
      else if ((state == S_CORE_RST) || (state == S_DRAIN))
        ph_cnt <= ph_cnt + PH_W'(1);
      core_rst_no <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      busy_o      <= (state_nxt == S_CORE_RST) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done_o      <= (state_nxt == S_DONE);
      if (launch)
        timeout_o <= 1'b0;
      else if ((state == S_RUN) && (state_nxt == S_DONE))
        timeout_o <= 1'b1;
    end
  end

  // Event counters, all saturating
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_cnt  <= '0;
      br_cnt   <= '0;
      miss_cnt <= '0;
      miss_pc  <= '0;
    end else if (launch) begin
      cyc_cnt  <= '0;
      br_cnt   <= '0;
      miss_cnt <= '0;
      miss_pc  <= '0;
    end else begin
      if (state == S_RUN) cyc_cnt <= cyc_inc;
      if (br_evt)         br_cnt  <= sat_inc(br_cnt);
      if (miss_evt) begin
        miss_cnt <= sat_inc(miss_cnt);
        miss_pc  <= t_instr_i;
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    case (rd_addr_i)
      2'd0:    rd_sel = cyc_cnt;
      2'd1:    rd_sel = br_cnt;
      2'd2:    rd_sel = miss_cnt;
      default: rd_sel = CNT_WIDTH'(miss_pc);
    endcase
  end

  // Read port returns the value held before this cycle's update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_vld_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_sel;
    end
  end

endmodule

// File: tb/tb_bp_run_ctrl.sv
// Bench for bp_run_ctrl: two differently parameterised instances share stimulus and are
// checked every cycle against a behavioural run model, plus directed literal expectations.
module tb_bp_run_ctrl;

  localparam int M_IDLE = 0, M_CRST = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4;

  typedef struct {
    int              mode;
    int              ph;
    longint unsigned cyc;
    longint unsigned br;
    longint unsigned ms;
    logic [31:0]     pc;
    bit              tmo;
    bit              vld;
    longint unsigned data;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        br = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] tpc = '0;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_addr = '0;

  logic        a_cr, a_busy, a_done, a_tmo, a_vld;
  logic [31:0] a_data;
  logic        b_cr, b_busy, b_done, b_tmo, b_vld;
  logic [3:0]  b_data;

  int checks = 0;
  int errors = 0;
  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  bp_run_ctrl #(.CNT_WIDTH(32), .CORE_RST_CYCLES(4), .DRAIN_CYCLES(4),
                .HALT_INSN(32'h0000_0073), .TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .br_instr_i(br), .br_miss_i(miss),
    .instr_i(instr), .t_instr_i(tpc), .core_rst_no(a_cr), .busy_o(a_busy),
    .done_o(a_done), .timeout_o(a_tmo), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_vld_o(a_vld), .rd_data_o(a_data));

  bp_run_ctrl #(.CNT_WIDTH(4), .CORE_RST_CYCLES(2), .DRAIN_CYCLES(3),
                .HALT_INSN(32'h0000_0073), .TIMEOUT(20)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .br_instr_i(br), .br_miss_i(miss),
    .instr_i(instr), .t_instr_i(tpc), .core_rst_no(b_cr), .busy_o(b_busy),
    .done_o(b_done), .timeout_o(b_tmo), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_vld_o(b_vld), .rd_data_o(b_data));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the run as described behaviourally: events, phase lengths, limits
  function automatic mdl_t mstep(input mdl_t m, input int w, input int crc, input int dc,
                                 input longint unsigned to);
    mdl_t n;
    longint unsigned mask;
    n = m;
    mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    n.vld = rd_req;
    if (rd_req) begin
      case (rd_addr)
        2'd0:    n.data = m.cyc;
        2'd1:    n.data = m.br;
        2'd2:    n.data = m.ms;
        default: n.data = 64'(m.pc) & mask;
      endcase
    end
    if ((m.mode == M_RUN || m.mode == M_DRAIN) && br) begin
      n.br = (m.br < mask) ? m.br + 1 : m.br;
      if (miss) begin
        n.ms = (m.ms < mask) ? m.ms + 1 : m.ms;
        n.pc = tpc;
      end
    end
    case (m.mode)
      M_IDLE, M_DONE: if (start) begin
        n.mode = M_CRST; n.ph = 0; n.cyc = 0; n.br = 0; n.ms = 0; n.pc = '0; n.tmo = 1'b0;
      end
      M_CRST: begin
        n.ph = m.ph + 1;
        if (n.ph == crc) n.mode = M_RUN;
      end
      M_RUN: begin
        n.cyc = (m.cyc < mask) ? m.cyc + 1 : m.cyc;
        if (instr == 32'h0000_0073) begin
          n.mode = M_DRAIN; n.ph = 0;
        end else if (n.cyc >= to) begin
          n.mode = M_DONE; n.tmo = 1'b1;
        end
      end
      M_DRAIN: begin
        n.ph = m.ph + 1;
        if (n.ph == dc) n.mode = M_DONE;
      end
      default: n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = mstep(ma, 32, 4, 4, 64'd16);
      mb = mstep(mb, 4, 2, 3, 64'd20);
    end
  end

  function automatic logic [63:0] run_on(input int mode);
    return 64'((mode == M_RUN) || (mode == M_DRAIN));
  endfunction
  function automatic logic [63:0] is_busy(input int mode);
    return 64'((mode == M_CRST) || (mode == M_RUN) || (mode == M_DRAIN));
  endfunction

  always @(negedge clk) begin
    chk("a_core_rst_no", 64'(a_cr), run_on(ma.mode));
    chk("a_busy", 64'(a_busy), is_busy(ma.mode));
    chk("a_done", 64'(a_done), 64'(ma.mode == M_DONE));
    chk("a_timeout", 64'(a_tmo), 64'(ma.tmo));
    chk("a_rd_vld", 64'(a_vld), 64'(ma.vld));
    if (ma.vld) chk("a_rd_data", 64'(a_data), ma.data);
    chk("b_core_rst_no", 64'(b_cr), run_on(mb.mode));
    chk("b_busy", 64'(b_busy), is_busy(mb.mode));
    chk("b_done", 64'(b_done), 64'(mb.mode == M_DONE));
    chk("b_timeout", 64'(b_tmo), 64'(mb.tmo));
    chk("b_rd_vld", 64'(b_vld), 64'(mb.vld));
    if (mb.vld) chk("b_rd_data", 64'(b_data), mb.data);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
    rd_req = 1'b1;
    rd_addr = addr;
    tick();
    rd_req = 1'b0;
    chk({name, "_vld"}, 64'(a_vld), 64'd1);
    chk(name, 64'(a_data), 64'(exp));
  endtask

  task automatic launch_run(input string name);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!a_cr && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_run_reached"}, 64'(a_cr), 64'd1);
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!a_done && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_done"}, 64'(a_done), 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_core_rst_no", 64'(a_cr), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    rst = 1'b0;
    tick();

    // Core reset held low for four cycles, then released into the run
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("crst_low", 64'(a_cr), 64'd0);
      chk("crst_busy", 64'(a_busy), 64'd1);
      tick();
    end
    chk("crst_release", 64'(a_cr), 64'd1);
    for (int i = 0; i < 10; i++) begin
      br = 1'b1;
      miss = (i == 2 || i == 5 || i == 9);
      tpc = (i == 9) ? 32'h0000_0120 : 32'h0000_0040 + 32'(i);
      tick();
    end
    br = 1'b0;
    miss = 1'b0;
    instr = 32'h0000_0073;
    tick();
    instr = '0;
    wait_done("run1", n);
    chk("run1_drain_len", 64'(n), 64'd4);
    chk("run1_timeout", 64'(a_tmo), 64'd0);
    br = 1'b1;
    miss = 1'b1;
    tpc = 32'h0000_dead;
    tick();
    br = 1'b0;
    miss = 1'b0;
    rd(2'd0, 32'd11, "run1_cycles");
    rd(2'd1, 32'd10, "run1_branches");
    rd(2'd2, 32'd3, "run1_misses");
    rd(2'd3, 32'h0000_0120, "run1_last_pc");

    // Read racing a branch sees the old count; a miss in the drain window still counts
    launch_run("run2");
    br = 1'b1;
    rd_req = 1'b1;
    rd_addr = 2'd1;
    tick();
    chk("run2_rd_old", 64'(a_data), 64'd0);
    br = 1'b0;
    instr = 32'h0000_0073;
    tick();
    chk("run2_rd_new", 64'(a_data), 64'd1);
    rd_req = 1'b0;
    instr = '0;
    tick();
    br = 1'b1;
    miss = 1'b1;
    tpc = 32'h0000_0200;
    tick();
    br = 1'b0;
    miss = 1'b0;
    wait_done("run2", n);
    br = 1'b1;
    miss = 1'b1;
    tpc = 32'h0000_0300;
    tick();
    br = 1'b0;
    miss = 1'b0;
    rd(2'd2, 32'd1, "run2_misses");
    rd(2'd3, 32'h0000_0200, "run2_last_pc");
    rd(2'd1, 32'd2, "run2_branches");

    // No halt: run ends on the cycle limit with no drain
    launch_run("run3");
    wait_done("run3", n);
    chk("run3_run_len", 64'(n), 64'd16);
    chk("run3_timeout", 64'(a_tmo), 64'd1);
    rd(2'd0, 32'd16, "run3_cycles");

    // Start ignored mid-run; reset aborts immediately and clears everything
    launch_run("run4");
    start = 1'b1;
    br = 1'b1;
    tick();
    start = 1'b0;
    chk("run4_start_ignored", 64'(a_cr), 64'd1);
    tick();
    tick();
    br = 1'b0;
    rst = 1'b1;
    #1;
    chk("run4_rst_cr", 64'(a_cr), 64'd0);
    chk("run4_rst_busy", 64'(a_busy), 64'd0);
    chk("run4_rst_done", 64'(a_done), 64'd0);
    chk("run4_rst_data", 64'(a_data), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    rd(2'd0, 32'd0, "run4_cycles");
    rd(2'd1, 32'd0, "run4_branches");
    rd(2'd2, 32'd0, "run4_misses");
    rd(2'd3, 32'd0, "run4_last_pc");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 3) != 0);
      miss = ($urandom_range(0, 2) == 0);
      instr = ($urandom_range(0, 24) == 0) ? 32'h0000_0073 : $urandom;
      tpc = $urandom;
      rd_req = ($urandom_range(0, 1) == 1);
      rd_addr = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_run_ctrl.md
BP_RUN_CTRL -- requirements
Module: bp_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of every event counter.
REQ-002 SHALL have parameter CORE_RST_CYCLES, default 4: cycles core reset is held before a run.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4: cycles after halt detection during which in-flight branches are still counted.
REQ-004 SHALL have parameter HALT_INSN, default 32'h0000_0073: fetched instruction word that ends a run.
REQ-005 SHALL have parameter TIMEOUT, default 1_000_000: run cycle limit.
REQ-006 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous assert, active-high.
REQ-008 SHALL have port start_i  input  1  run request pulse.
REQ-009 SHALL have port br_instr_i  input  1  branch/jump resolved in EX/MEM this cycle.
REQ-010 SHALL have port br_miss_i  input  1  mispredict flush this cycle.
REQ-011 SHALL have port instr_i  input  32  IF-stage instruction word.
REQ-012 SHALL have port t_instr_i  input  32  PC of the resolving branch.
REQ-013 SHALL have port core_rst_no  output  1  active-low reset driven to the predictor core.
REQ-014 SHALL have port busy_o  output  1  high in CORE_RST, RUN, DRAIN.
REQ-015 SHALL have port done_o  output  1  high in DONE.
REQ-016 SHALL have port timeout_o  output  1  run ended by TIMEOUT.
REQ-017 SHALL have ports rd_req_i  input  1, rd_addr_i  input  2, rd_vld_o  output  1, rd_data_o  output  CNT_WIDTH: counter read port.

Function
REQ-018 SHALL implement states IDLE, CORE_RST, RUN, DRAIN, DONE.
REQ-019 IDLE/DONE: start_i=1 SHALL go to CORE_RST and clear all counters, last-miss PC and timeout_o.
REQ-020 start_i SHALL be ignored in CORE_RST, RUN, DRAIN.
REQ-021 CORE_RST SHALL drive core_rst_no=0 for exactly CORE_RST_CYCLES cycles, then enter RUN.
REQ-022 core_rst_no SHALL be 1 only in RUN and DRAIN; 0 in all other states.
REQ-023 RUN: cycle counter (addr 0) SHALL increment by 1 every cycle.
REQ-024 RUN/DRAIN: br_instr_i=1 SHALL increment branch counter (addr 1).
REQ-025 RUN/DRAIN: br_instr_i=1 and br_miss_i=1 SHALL increment miss counter (addr 2) and load t_instr_i into last-miss PC (addr 3); br_miss_i without br_instr_i SHALL be ignored.
REQ-026 Every counter SHALL saturate at all-ones, no wrap.
REQ-027 RUN: instr_i==HALT_INSN SHALL enter DRAIN next cycle; the branch event in that same cycle SHALL be counted.
REQ-028 RUN: cycle counter reaching TIMEOUT SHALL enter DONE with timeout_o=1, no DRAIN; halt and timeout in the same cycle SHALL take halt.
REQ-029 DRAIN: cycle counter frozen; after exactly DRAIN_CYCLES cycles SHALL enter DONE with timeout_o=0.
REQ-030 Read: rd_req_i=1 in cycle N SHALL give rd_vld_o=1 and rd_data_o=selected register in cycle N+1, single-cycle pulse; legal in any state; value is the pre-update value of cycle N.
REQ-031 Addr 3 SHALL return last-miss PC zero-extended or truncated to CNT_WIDTH.

Reset
REQ-032 rst_i=1 SHALL immediately force IDLE, core_rst_no=0, busy_o=0, done_o=0, timeout_o=0, rd_vld_o=0, rd_data_o=0, all counters and last-miss PC=0.
REQ-033 rst_i asserted mid-run SHALL abort the run with no DONE indication; next start_i after release SHALL start a fresh run.

Verification
REQ-034 start_i pulse from IDLE -> core_rst_no low 4 cycles, then high, busy_o=1.
REQ-035 RUN with 10 br_instr_i pulses, 3 with br_miss_i (last t_instr_i=32'h0000_0120), then instr_i=32'h0000_0073 -> DRAIN 4 cycles, DONE; reads return branches=10, misses=3, addr3=32'h120.
REQ-036 Branch with miss during DRAIN cycle 2 -> counted (misses +1); none counted after DONE.
REQ-037 TIMEOUT=16, no halt -> DONE after 16 RUN cycles, timeout_o=1, cycles=16.
REQ-038 rst_i pulse mid-RUN -> immediate IDLE, all reads return 0; start_i in RUN ignored.
REQ-039 rd_req_i on addr 1 in same cycle as branch event -> rd_data_o shows old count, next read shows +1.
